// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared state type and CRC-8 constants for the configuration-chain loader
package ccff_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/ccff_crc8.sv
// ccff_crc8: serial CRC-8 register with synchronous clear and per-bit enable
module ccff_crc8
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);
  always_ff @(posedge clk)
    if (rst || clr) crc <= CRC8_INIT;
    else if (en) crc <= crc8_step(crc, bit_in);
endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: serializes a bitstream into the config chain and optionally CRC-verifies it by recirculation
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 512,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              cfg_ok,
  output logic              cfg_err
);
  localparam int ACC_W = $clog2(CHAIN_LEN + WORD_W + 1);
  localparam int BC_W  = $clog2(WORD_W + 1);
  state_t            state;
  logic [WORD_W-1:0] word_buf;
  logic [BC_W-1:0]   buf_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ACC_W-1:0]  acc_cnt;
  logic [ACC_W-1:0]  rem;
  logic [7:0]        crc_wr;
  logic [7:0]        crc_rd;
  logic              ver_q;
  logic              ok_q;
  logic              err_q;
  logic              shifting;
  logic              verifying;
  logic              take;
  logic              last_bit;
  logic              clr;
  logic              match;
  assign shifting      = state == LOAD && buf_cnt != '0;
  assign verifying     = state == VERIFY;
  assign bs_ready      = state == LOAD && (buf_cnt == '0 || (buf_cnt == BC_W'(1) && shifting))
                         && acc_cnt < ACC_W'(CHAIN_LEN);
  assign take          = bs_valid && bs_ready;
  assign rem           = ACC_W'(CHAIN_LEN) - acc_cnt;
  assign last_bit      = bit_cnt == CNT_W'(CHAIN_LEN - 1);
  assign clr           = state == IDLE && start;
  assign match         = crc_rd == crc_wr;
  assign ccff_shift_en = shifting || verifying;
  assign ccff_head     = shifting ? word_buf[WORD_W-1] : (verifying && ccff_tail);
  assign busy          = state != IDLE;
  assign done          = state == DONE;
  assign cfg_ok        = done ? (ver_q && match) : ok_q;
  assign cfg_err       = done ? (ver_q && !match) : err_q;
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state    <= IDLE;
      word_buf <= '0;
      buf_cnt  <= '0;
      bit_cnt  <= '0;
      acc_cnt  <= '0;
      ver_q    <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= LOAD;
          word_buf <= '0;
          buf_cnt  <= '0;
          bit_cnt  <= '0;
          acc_cnt  <= '0;
          ver_q    <= verify_en;
          ok_q     <= 1'b0;
          err_q    <= 1'b0;
        end
        LOAD: begin
          if (take) begin
            word_buf <= bs_data;
            buf_cnt  <= rem < ACC_W'(WORD_W) ? BC_W'(rem) : BC_W'(WORD_W);
            acc_cnt  <= acc_cnt + ACC_W'(WORD_W);
          end else if (shifting) begin
            word_buf <= word_buf << 1;
            buf_cnt  <= buf_cnt - 1'b1;
          end
          if (shifting) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            if (last_bit) state <= ver_q ? VERIFY : DONE;
          end
        end
        VERIFY: begin
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          if (last_bit) state <= DONE;
        end
        default: begin
          ok_q  <= ver_q && match;
          err_q <= ver_q && !match;
          state <= IDLE;
        end
      endcase
    end
  end
  ccff_crc8 u_crc_wr (
    .clk    (prog_clk),
    .rst    (prog_reset),
    .clr    (clr),
    .en     (shifting),
    .bit_in (word_buf[WORD_W-1]),
    .crc    (crc_wr)
  );
  ccff_crc8 u_crc_rd (
    .clk    (prog_clk),
    .rst    (prog_reset),
    .clr    (clr),
    .en     (verifying),
    .bit_in (ccff_tail),
    .crc    (crc_rd)
  );
endmodule
